// File: rtl/feed_sequencer.sv
// Feeder sequencer: waits for a timer expiry or a manual request, runs the
// dispensing motor until the requested portions are counted, lets the
// mechanism settle, then pulses a timer reload. If no sensor pulse arrives
// within the timeout, it latches a jam/empty fault.
// Optional feature macro: FEED_COUNT_EN (saturating completed-feed counter).
module feed_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
  parameter logic [31:0] SETTLE_CYCLES  = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m_state,
  input  logic       timer_done,
  input  logic       manual_feed,
  input  logic       sensor_on,
  input  logic [2:0] porciones,
  input  logic       clear_fault,
  output logic       motor_on,
  output logic       timer_reload,
  output logic       busy,
  output logic       fault,
  output logic [2:0] portions_done,
  output logic [2:0] state_o,
  output logic [7:0] feed_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DISPENSE = 3'd2,
    SETTLE   = 3'd3,
    RELOAD   = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t      state;
  logic        sensor_q;
  logic        sensor_rise;
  logic [2:0]  target;
  logic [2:0]  next_portions;
  logic [31:0] cnt;
  logic        auto_feed;
  logic        start_req;
  logic        settle_done;

  assign sensor_rise   = sensor_on & ~sensor_q;
  assign next_portions = portions_done + 3'd1;
  assign settle_done   = (state == SETTLE) && (cnt == SETTLE_CYCLES - 32'd1);
  // A manual request always starts a feed from IDLE/ARMED; a timer expiry only
  // starts one while scheduled feeding is enabled.
  assign start_req     = ((state == IDLE) && manual_feed) ||
                         ((state == ARMED) && (manual_feed || (timer_done && m_state)));
  assign state_o       = state;

  // One-cycle delayed copy of the sensor level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sensor_q <= 1'b0;
    else        sensor_q <= sensor_on;
  end

  // Main sequencing FSM; outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      motor_on      <= 1'b0;
      timer_reload  <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      portions_done <= 3'd0;
      target        <= 3'd0;
      cnt           <= 32'd0;
      auto_feed     <= 1'b0;
    end else begin
      timer_reload <= 1'b0;
      if (start_req) begin
        target        <= porciones;
        portions_done <= 3'd0;
        cnt           <= 32'd0;
        auto_feed     <= ~manual_feed;
        busy          <= 1'b1;
        if (porciones == 3'd0) begin
          state    <= SETTLE;
          motor_on <= 1'b0;
        end else begin
          state    <= DISPENSE;
          motor_on <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (m_state) state <= ARMED;
          end
          ARMED: begin
            if (!m_state) state <= IDLE;
          end
          DISPENSE: begin
            if (auto_feed && !m_state) begin
              state    <= IDLE;
              motor_on <= 1'b0;
              busy     <= 1'b0;
            end else if (sensor_rise) begin
              portions_done <= next_portions;
              cnt           <= 32'd0;
              if (next_portions == target) begin
                state    <= SETTLE;
                motor_on <= 1'b0;
              end
            end else if (cnt == TIMEOUT_CYCLES - 32'd1) begin
              state    <= FAULT;
              motor_on <= 1'b0;
              busy     <= 1'b0;
              fault    <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          SETTLE: begin
            if (settle_done) begin
              state        <= RELOAD;
              busy         <= 1'b0;
              timer_reload <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          RELOAD: begin
            state <= m_state ? ARMED : IDLE;
          end
          FAULT: begin
            if (clear_fault) begin
              state <= IDLE;
              fault <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            motor_on <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FEED_COUNT_EN
  // Completed-feed counter, bumped as the sequencer enters RELOAD, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              feed_count <= 8'd0;
    else if (settle_done && !start_req && feed_count != 8'hFF) feed_count <= feed_count + 8'd1;
  end
`else
  assign feed_count = 8'd0;
`endif

endmodule
